dmem_lsu: RTL and testbench

Parametrised successor data memory for the RV32I core: a word-organised RAM behind a request/valid handshake with RV32I load/store sizing (byte/half/word, sign/zero extension), byte-lane write strobes, programmable wait states, and address-range error reporting. It sits between the core's MEM stage and the data array. The MEM stage holds its request until `READY` and stalls until `VALID`.

---
 rtl/dmem_lsu.sv | 174 +++++++++++++++++
 tb/tb_dmem_lsu.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: word RAM with RV32I load/store sizing, wait states, fault report.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_lsu #(
  parameter logic [31:0] DMEM_BASE   = 32'h0010_0000,
  parameter int          DMEM_SIZE   = 32768,
  parameter string       DMEM_FILE   = "data.mif",
  parameter int          WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ,
  input  logic        WE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic        READY,
  output logic        VALID,
  output logic [31:0] RD,
  output logic        ERR
);

  localparam int          IW     = $clog2(DMEM_SIZE);
  localparam logic [31:0] NBYTES = 32'(DMEM_SIZE) << 2;
  localparam logic [3:0]  WS     = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] a_q, wd_q;
  logic [31:0] rd_q;
  logic        err_q;
  logic        accept, commit;

  logic        use_in, we_c;
  logic [2:0]  f3_c;
  logic [31:0] a_c, wd_c, off;
  logic [IW-1:0] idx;
  logic [31:0] word, wdat, ld;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [3:0]  be;
  logic        f3_err, rng_err, mis, err_c;

  logic [31:0] mem_q [DMEM_SIZE];

  // In IDLE the access commits on the accept edge, so use live inputs
  always_comb begin
    use_in  = (state_q == S_IDLE);
    we_c    = use_in ? WE     : we_q;
    f3_c    = use_in ? FUNCT3 : f3_q;
    a_c     = use_in ? A      : a_q;
    wd_c    = use_in ? WD     : wd_q;
    off     = a_c - DMEM_BASE;
    idx     = off[IW+1:2];
    rng_err = (a_c < DMEM_BASE) || (off >= NBYTES);
    word    = mem_q[idx];
    byte_v  = word[{a_c[1:0], 3'b000} +: 8];
    half_v  = a_c[1] ? word[31:16] : word[15:0];
    f3_err  = 1'b0;
    be      = 4'b0000;
    wdat    = wd_c;
    ld      = word;
    case (f3_c)
      3'b000: begin
        be   = 4'b0001 << a_c[1:0];
        wdat = {4{wd_c[7:0]}};
        ld   = {{24{byte_v[7]}}, byte_v};
      end
      3'b001: begin
        be   = a_c[1] ? 4'b1100 : 4'b0011;
        wdat = {2{wd_c[15:0]}};
        ld   = {{16{half_v[15]}}, half_v};
      end
      3'b010: begin
        be   = 4'b1111;
        wdat = wd_c;
        ld   = word;
      end
      3'b100: begin
        ld     = {24'h0, byte_v};
        f3_err = we_c;
      end
      3'b101: begin
        ld     = {16'h0, half_v};
        f3_err = we_c;
      end
      default: f3_err = 1'b1;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = ((f3_c[1:0] == 2'b01) && a_c[0]) ||
          ((f3_c[1:0] == 2'b10) && (a_c[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    err_c = f3_err | rng_err | mis;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (REQ) begin
          accept = 1'b1;
          if (WS == 4'd0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS - 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      a_q     <= 32'h0;
      wd_q    <= 32'h0;
      rd_q    <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q <= WE;
        f3_q <= FUNCT3;
        a_q  <= A;
        wd_q <= WD;
      end
      if (commit) begin
        err_q <= err_c;
        rd_q  <= (err_c || we_c) ? 32'h0 : ld;
      end
    end
  end

  // Array has no reset; a fault suppresses the write entirely
  always_ff @(posedge CLK) begin
    if (commit && we_c && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  always_comb begin
    READY = (state_q == S_IDLE);
    VALID = (state_q == S_RESP);
    RD    = rd_q;
    ERR   = err_q;
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed self-checking bench for dmem_lsu.
// WAIT_STATES=2, small array, no init image.
module tb_dmem_lsu;

  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int          SZ   = 1024;
  localparam logic [31:0] TOP  = BASE + 32'(SZ) * 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ, WE;
  logic [2:0]  FUNCT3;
  logic [31:0] A, WD;
  logic        READY, VALID;
  logic [31:0] RD;
  logic        ERR;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dmem_lsu #(
    .DMEM_BASE  (BASE),
    .DMEM_SIZE  (SZ),
    .DMEM_FILE  (""),
    .WAIT_STATES(2)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ   (REQ),
    .WE    (WE),
    .FUNCT3(FUNCT3),
    .A     (A),
    .WD    (WD),
    .READY (READY),
    .VALID (VALID),
    .RD    (RD),
    .ERR   (ERR)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a negedge; fields are scrambled after accept
  task automatic acc(input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err,
                     output int lat);
    int n;
    REQ = 1'b1; WE = we; FUNCT3 = f3; A = a; WD = wd;
    n = 0;
    while (!READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_before_accept", {31'b0, READY}, 32'd1);
    @(posedge CLK);
    #1;
    REQ = 1'b0; WE = ~we; FUNCT3 = 3'b111; A = ~a; WD = ~wd;
    lat = -1; rd = 32'hx; err = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (VALID) begin
        lat = i; rd = RD; err = ERR;
        break;
      end
    end
    @(negedge CLK);
    chk("valid_one_cycle", {31'b0, VALID}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  logic        seen;

  initial begin
    RST_N = 1'b0; REQ = 1'b0; WE = 1'b0;
    FUNCT3 = 3'b000; A = 32'h0; WD = 32'h0;
    repeat (2) @(negedge CLK);
    chk("rst_ready", {31'b0, READY}, 32'd1);
    chk("rst_valid", {31'b0, VALID}, 32'd0);
    chk("rst_rd", RD, 32'h0);
    chk("rst_err", {31'b0, ERR}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    acc(1'b1, 3'b010, BASE, 32'hDEADBEEF, rd, err, lat);
    chk("sw_latency", lat, 32'd3);
    chk("sw_err", {31'b0, err}, 32'd0);
    chk("sw_rd", rd, 32'h0);
    acc(1'b0, 3'b010, BASE, 32'h0, rd, err, lat);
    chk("lw_latency", lat, 32'd3);
    chk("lw_rd", rd, 32'hDEADBEEF);
    chk("lw_err", {31'b0, err}, 32'd0);

    acc(1'b1, 3'b010, BASE, 32'h0, rd, err, lat);
    acc(1'b1, 3'b000, BASE + 3, 32'hAAAA_AA80, rd, err, lat);
    acc(1'b0, 3'b010, BASE, 32'h0, rd, err, lat);
    chk("sb_word", rd, 32'h8000_0000);
    acc(1'b0, 3'b000, BASE + 3, 32'h0, rd, err, lat);
    chk("lb_sext", rd, 32'hFFFF_FF80);
    acc(1'b0, 3'b100, BASE + 3, 32'h0, rd, err, lat);
    chk("lbu_zext", rd, 32'h0000_0080);

    acc(1'b1, 3'b010, BASE + 4, 32'h1234_5678, rd, err, lat);
    acc(1'b1, 3'b001, BASE + 6, 32'hFFFF_8001, rd, err, lat);
    acc(1'b0, 3'b001, BASE + 6, 32'h0, rd, err, lat);
    chk("lh_sext", rd, 32'hFFFF_8001);
    acc(1'b0, 3'b101, BASE + 6, 32'h0, rd, err, lat);
    chk("lhu_zext", rd, 32'h0000_8001);
    acc(1'b0, 3'b010, BASE + 4, 32'h0, rd, err, lat);
    chk("sh_word", rd, 32'h8001_5678);
    acc(1'b0, 3'b001, BASE + 4, 32'h0, rd, err, lat);
    chk("lh_low", rd, 32'h0000_5678);

    acc(1'b1, 3'b010, 32'h000F_FFFC, 32'h5555_5555, rd, err, lat);
    chk("below_err", {31'b0, err}, 32'd1);
    chk("below_rd", rd, 32'h0);
    acc(1'b1, 3'b010, TOP, 32'h5555_5555, rd, err, lat);
    chk("above_err", {31'b0, err}, 32'd1);
    acc(1'b0, 3'b010, TOP, 32'h0, rd, err, lat);
    chk("above_ld_err", {31'b0, err}, 32'd1);
    chk("above_ld_rd", rd, 32'h0);
    acc(1'b0, 3'b010, TOP - 4, 32'h0, rd, err, lat);
    chk("last_word_ok", {31'b0, err}, 32'd0);
    acc(1'b1, 3'b100, BASE, 32'h5555_5555, rd, err, lat);
    chk("sbu_err", {31'b0, err}, 32'd1);
    acc(1'b0, 3'b011, BASE, 32'h0, rd, err, lat);
    chk("f3_011_err", {31'b0, err}, 32'd1);
    chk("f3_011_rd", rd, 32'h0);
    acc(1'b0, 3'b010, BASE, 32'h0, rd, err, lat);
    chk("unchanged", rd, 32'h8000_0000);

    acc(1'b0, 3'b010, BASE + 1, 32'h0, rd, err, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_err", {31'b0, err}, 32'd1);
    chk("mis_rd", rd, 32'h0);
`else
    chk("mis_err", {31'b0, err}, 32'd0);
    chk("mis_rd", rd, 32'h8000_0000);
`endif

    acc(1'b1, 3'b010, BASE + 8, 32'h1111_1111, rd, err, lat);
    REQ = 1'b1; WE = 1'b1; FUNCT3 = 3'b010;
    A = BASE + 8; WD = 32'hCAFE_F00D;
    @(posedge CLK);
    #1 REQ = 1'b0;
    @(negedge CLK);
    #1 RST_N = 1'b0;
    #1;
    chk("rst_wait_ready", {31'b0, READY}, 32'd1);
    chk("rst_wait_valid", {31'b0, VALID}, 32'd0);
    #1 RST_N = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      seen = seen | VALID;
    end
    chk("rst_no_valid", {31'b0, seen}, 32'd0);
    acc(1'b0, 3'b010, BASE + 8, 32'h0, rd, err, lat);
    chk("rst_old_data", rd, 32'h1111_1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
